// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/flush controller; define PIPE_CTRL_PERF_EN to add perf counters
module pipe_stall_ctrl #(
    parameter int PERF_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic hazard_stall,
    input  logic ex_branch_taken,
    input  logic imem_ready,
    input  logic dmem_req,
    input  logic dmem_ready,
    output logic pc_we,
    output logic if_id_we,
    output logic id_ex_we,
    output logic ex_mem_we,
    output logic mem_wb_we,
    output logic if_id_flush,
    output logic id_ex_flush,
    output logic mem_wb_flush,
    output logic pc_sel_redirect
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_redirects,
    output logic [PERF_WIDTH-1:0] perf_dwait_cycles
`endif
);
    localparam logic [1:0] RUN = 2'd0, DWAIT = 2'd1, REDIR = 2'd2;
    logic [1:0] state, state_next;
    logic redir_pend, redir_pend_next;
    logic in_redir, r1, r2, r3, r4, r5;
    if (PERF_WIDTH < 1) begin : g_bad_width
        $error("PERF_WIDTH must be at least 1");
    end
    assign in_redir = state == REDIR;
    assign r1 = dmem_req && !dmem_ready;
    assign r2 = !r1 && ex_branch_taken && !in_redir;
    assign r3 = !r1 && !r2 && in_redir;
    assign r4 = !r1 && !r2 && !r3 && hazard_stall;
    assign r5 = !r1 && !r2 && !r3 && !r4 && !imem_ready;
    // state and pending-redirect registers
    always_ff @(posedge clk) begin
        state      <= state_next;
        redir_pend <= redir_pend_next;
    end
    // next state: freeze wins; a drop owed before a freeze is resumed on release
    always_comb begin
        state_next = rst ? RUN :
                     r1 ? DWAIT :
                     ((state == DWAIT && redir_pend) || ((r2 || r3) && !imem_ready)) ? REDIR : RUN;
        redir_pend_next = !rst && r1 && (redir_pend || in_redir);
    end
    // per-stage enables and bubbles; reset holds every stage flushed
    always_comb begin
        pc_we           = !rst && !r1 && !r3 && !r4 && !r5;
        if_id_we        = !rst && !r1 && !r4;
        id_ex_we        = !rst && !r1;
        ex_mem_we       = !rst && !r1;
        mem_wb_we       = !rst && !r1;
        if_id_flush     = rst || r2 || r3 || r5;
        id_ex_flush     = rst || r2 || r4;
        mem_wb_flush    = rst || r1;
        pc_sel_redirect = !rst && r2;
    end
`ifdef PIPE_CTRL_PERF_EN
    // free-running event counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
            perf_dwait_cycles <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + PERF_WIDTH'(!pc_we);
            perf_redirects    <= perf_redirects + PERF_WIDTH'(r2);
            perf_dwait_cycles <= perf_dwait_cycles + PERF_WIDTH'(r1);
        end
    end
`endif
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the 5-stage pipeline. It merges the load-use stall, the EX-stage branch redirect, instruction-memory wait and data-memory wait into one consistent set of per-stage write-enable and flush controls. A small FSM handles two cases that span several cycles: data-memory wait, and dropping a stale instruction fetch after a redirect.

## Interface
- PERF_WIDTH, 32, width of performance counters (only used with PIPE_CTRL_PERF_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- hazard_stall  in  1  load-use stall request from the data-hazard detector
- ex_branch_taken  in  1  EX resolved taken branch/jump; target is valid this cycle
- imem_ready  in  1  instruction for the current fetch is valid this cycle
- dmem_req  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data memory completes the MEM access this cycle
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register load enable
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble; overrides the matching _we
- pc_sel_redirect  out  1  PC mux selects the EX branch target
- perf_stall_cycles, perf_redirects, perf_dwait_cycles  out  PERF_WIDTH each  (PIPE_CTRL_PERF_EN only)

## Operation
- States: RUN, DWAIT, REDIR (2-bit encoding). Reset state: RUN.
- Outputs are combinational from state and inputs. Evaluate each cycle in priority order; the first match wins:
  1. dmem_req && !dmem_ready (freeze): all _we = 0, mem_wb_flush = 1, other flushes 0, pc_sel_redirect = 0. Next state DWAIT. Branch and hazard inputs are ignored because EX and ID are held and the inputs are re-presented.
  2. ex_branch_taken, state not REDIR: pc_sel_redirect = 1, pc_we = 1, if_id_flush = 1, id_ex_flush = 1, ex_mem_we = mem_wb_we = 1.
     - Next state: REDIR if !imem_ready (the old fetch is still in flight), else RUN.
  3. State REDIR: pc_we = 0, if_id_flush = 1, downstream stages advance.
     - On imem_ready, the returned instruction is the stale wrong-path fetch. It is dropped and the next state is RUN.
     - Otherwise stay in REDIR.
     - A new ex_branch_taken cannot occur here, because ID/EX holds a bubble.
  4. hazard_stall: pc_we = 0, if_id_we = 0, id_ex_flush = 1, ex_mem_we = mem_wb_we = 1.
  5. !imem_ready: pc_we = 0, if_id_flush = 1, all downstream stages advance.
  6. Otherwise: every _we = 1, every flush = 0.
- DWAIT exit: when dmem_ready = 1, rules 2–6 apply in that same cycle and the next state is RUN.
- DWAIT entered from REDIR: the stale-fetch drop must survive the freeze.
  - A sticky bit, redir_pend, is set when rule 1 fires while in REDIR.
  - On DWAIT exit with redir_pend set, the next state is REDIR, not RUN, and redir_pend is cleared.
- While rst = 1: all _we = 0, all flushes = 1, pc_sel_redirect = 0, next state RUN, redir_pend = 0.

## Timing
- Inputs to outputs: zero-cycle combinational, with no path through the counters.
- State and redir_pend update on clk; the effect appears in the cycle after the event.
- Load-use costs exactly 1 bubble, because the detector drops its request once the bubble enters ID/EX.
- Redirect penalty: 2 bubbles when imem_ready = 1 in the branch cycle, otherwise 2 + the number of REDIR cycles.
- Data wait of N cycles with dmem_ready low: exactly N freeze cycles. MEM/WB receives N bubbles, and WB of the frozen instruction is not duplicated.
- Simultaneous hazard_stall and ex_branch_taken: the branch wins. The stalled instruction is on the wrong path and is flushed.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Three free-running PERF_WIDTH counters, reset to 0, wrapping at 2^PERF_WIDTH.
  - perf_stall_cycles increments on every non-reset cycle with pc_we = 0.
  - perf_redirects increments on every cycle in which rule 2 fires.
  - perf_dwait_cycles increments on every cycle in which rule 1 fires.
- Not defined: the counter ports and logic are absent. Control behaviour is identical in both builds.

## Test plan
- Reset: hold rst 3 cycles with random inputs → all _we = 0, all flushes = 1, pc_sel_redirect = 0; the first cycle after release, with inputs idle and imem_ready = 1, gives all _we = 1.
- Load-use: hazard_stall = 1 for 1 cycle → pc_we = if_id_we = 0, id_ex_flush = 1, ex_mem_we = 1; the next cycle is normal; perf_stall_cycles += 1.
- Branch with imem_ready = 0 for 3 cycles after the branch: pc_sel_redirect = 1 in one cycle → REDIR for 3 cycles with if_id_flush = 1; the stale word on the 4th cycle is dropped; then RUN.
- Data wait: dmem_req = 1, dmem_ready low for 4 cycles → 4 cycles with all _we = 0 and mem_wb_flush = 1; perf_dwait_cycles = 4; a coincident ex_branch_taken takes effect only in the release cycle.
- Freeze in REDIR: enter REDIR, then dmem wait for 2 cycles → after release the state is REDIR and the next imem_ready word is still dropped.
- Simultaneous hazard_stall and ex_branch_taken → rule 2 outputs only; perf_redirects += 1; perf_stall_cycles unchanged, because pc_we = 1 in that cycle.
